mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_rr_arb2.sv | 19 +
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and the
// IDLE/ACCESS state encoding.
package mem_arb_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester grant logic: a lone requester always wins, and a tie goes to
// the port named by the priority pointer.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported memory with a shared
// bidirectional data bus; each accepted access occupies exactly one ACCESS cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output arb_state_t        o_dbg_state
);

  arb_state_t        r_state;
  logic              r_ptr;
  logic              r_id;
  logic              r_mem_wr;
  logic              r_mem_rd;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DWIDTH-1:0] r_rdata0;
  logic [DWIDTH-1:0] r_rdata1;

  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic              w_sel;
  logic              w_we;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req (rst ? 2'b00 : {req1, req0}),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // gnt only asserts on an active request, so a grant is by itself a transfer.
  assign gnt0    = w_gnt[0];
  assign gnt1    = w_gnt[1];
  assign w_xfer  = w_gnt[0] | w_gnt[1];
  assign w_sel   = w_gnt[1];
  assign w_we    = w_sel ? we1    : we0;
  assign w_addr  = w_sel ? addr1  : addr0;
  assign w_wdata = w_sel ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      // Read completion: the memory drives the bus throughout the read ACCESS cycle.
      r_rvalid0 <= r_mem_rd & ~r_id;
      r_rvalid1 <= r_mem_rd &  r_id;
      if (r_mem_rd) begin
        if (r_id) r_rdata1 <= mem_data;
        else      r_rdata0 <= mem_data;
      end
      if (w_xfer) begin
        r_state  <= ST_ACCESS;
        r_id     <= w_sel;
        r_ptr    <= ~w_sel;
        r_addr   <= w_addr;
        r_wdata  <= w_wdata;
        r_mem_wr <= w_we;
        r_mem_rd <= ~w_we;
      end else begin
        r_state  <= ST_IDLE;
        r_mem_wr <= 1'b0;
        r_mem_rd <= 1'b0;
      end
    end
  end

  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_addr;
  assign mem_data    = r_mem_wr ? r_wdata : {DWIDTH{1'bz}};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model with a shadow memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wr, mem_rd;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  arb_state_t    dbg_state;

  // Memory device attached to the bus, and the model's view of its contents.
  logic [DW-1:0] tb_mem [0:31];
  logic [DW-1:0] sh_mem [0:31];
  assign mem_data = mem_rd ? tb_mem[mem_addr] : {DW{1'bz}};

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .o_dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // Model: priority pointer, the access in flight, and expected read results.
  logic          m_ptr, p_valid, p_port, p_we;
  logic [AW-1:0] p_addr, m_addr;
  logic [DW-1:0] p_data;
  logic          e_rv0, e_rv1;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [1:0]    m_eg;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          dev_wr;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_gnt();
    if (rst) return 2'b00;
    if (req0 && req1) return m_ptr ? 2'b10 : 2'b01;
    return {req1, req0};
  endfunction

  task automatic model_reset();
    m_ptr = 1'b0; p_valid = 1'b0; p_port = 1'b0; p_we = 1'b0;
    p_addr = '0; p_data = '0; m_addr = '0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic check_cycle();
    m_eg = exp_gnt();
    chk("gnt0", 32'(gnt0), 32'(m_eg[0]));
    chk("gnt1", 32'(gnt1), 32'(m_eg[1]));
    chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
    chk("mem_wr", 32'(mem_wr), 32'(p_valid && p_we));
    chk("mem_rd", 32'(mem_rd), 32'(p_valid && !p_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (p_valid) chk("mem_data", 32'(mem_data), 32'(p_we ? p_data : sh_mem[p_addr]));
    chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
    chk("rdata0", 32'(rdata0), 32'(e_rd0));
    chk("rdata1", 32'(rdata1), 32'(e_rd1));
    chk("state", 32'(dbg_state), 32'(p_valid ? ST_ACCESS : ST_IDLE));
  endtask

  task automatic model_step();
    e_rv0 = 1'b0; e_rv1 = 1'b0;
    if (p_valid) begin
      if (p_we) sh_mem[p_addr] = p_data;
      else if (!p_port) begin
        e_rv0 = 1'b1;
        if (exp_q0.size() > 0) e_rd0 = exp_q0.pop_front();
      end else begin
        e_rv1 = 1'b1;
        if (exp_q1.size() > 0) e_rd1 = exp_q1.pop_front();
      end
    end
    p_valid = (m_eg != 2'b00);
    if (p_valid) begin
      p_port = m_eg[1];
      p_we   = p_port ? we1 : we0;
      p_addr = p_port ? addr1 : addr0;
      p_data = p_port ? wdata1 : wdata0;
      m_addr = p_addr;
      m_ptr  = ~p_port;
      if (!p_we) begin
        if (p_port) exp_q1.push_back(sh_mem[p_addr]);
        else        exp_q0.push_back(sh_mem[p_addr]);
      end
    end
  endtask

  // Check at the falling edge, then let the memory and the model advance at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    dev_wr = mem_wr; dev_addr = mem_addr; dev_data = mem_data;
    @(posedge clk);
    if (!rst) begin
      if (dev_wr) tb_mem[dev_addr] = dev_data;
      model_step();
    end
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = DW'($urandom);
      sh_mem[i] = tb_mem[i];
    end
    model_reset();
    drive(1, 0, 5'd4, 8'h00, 1, 1, 5'd6, 8'h11);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Port 0 write then read of address 0.
    drive(1, 1, 5'd0, 8'hFF, 0, 0, 5'd0, 8'h00);
    tick();
    drive(1, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();
    chk("wr_rd_rdata0", 32'(rdata0), 32'h0000_00FF);

    // Both ports requesting continuously from reset: grants alternate.
    drive(1, 0, 5'd2, 8'h00, 1, 0, 5'd9, 8'h00);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("alt_gnt", 32'({gnt1, gnt0}), (i % 2 == 1) ? 32'd2 : 32'd1);
      tick();
    end
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();

    // Port 1 back-to-back writes of ~addr, then back-to-back reads.
    for (int a = 31; a >= 1; a--) begin
      drive(0, 0, 5'd0, 8'h00, 1, 1, AW'(a), ~DW'(a));
      tick();
    end
    for (int a = 31; a >= 1; a--) begin
      drive(0, 0, 5'd0, 8'h00, 1, 0, AW'(a), 8'h00);
      tick();
    end
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();
    chk("p1_last_rdata1", 32'(rdata1), 32'h0000_00FE);

    // Tie with pointer at port 1: write wins, read then sees the new data.
    drive(1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    drive(1, 0, 5'd3, 8'h00, 1, 1, 5'd3, 8'h5A);
    tick();
    drive(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();
    chk("tie_rdata0", 32'(rdata0), 32'h0000_005A);

    // Reset in the middle of a read ACCESS cycle.
    drive(1, 0, 5'd9, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_rd", 32'(mem_rd), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    model_reset();
    tick();
    rst = 1'b0;
    drive(0, 0, 5'd0, 8'h00, 1, 1, 5'd12, 8'h33);
    #1;
    chk("post_reset_gnt1", 32'(gnt1), 32'd1);
    tick();
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();

    // Random traffic; address/data/we are randomized even when req is low.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 2) != 0), 1'($urandom), AW'($urandom), DW'($urandom));
      tick();
    end
    drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
